// File: rtl/mem_stage_pipe.sv
// ---------------------------------------------------------------------------
// mem_stage_pipe
//
// MEM stage of the 5-stage pipeline, between EX and WB.
// - Owns a word-addressed data memory (2**ADDR_W words).
// - Stores take one cycle.
// - Loads take READ_LAT cycles. Upstream is stalled for the first
//   READ_LAT-1 of them.
// - Every WB-bound signal is registered into the MEM/WB register.
//
// Optional feature (macro MEM_STAGE_PIPE_ERR_EN):
//   Adds the mem_err output. An access with nonzero upper address bits
//   raises mem_err, suppresses the store, returns 0 for a load, and forces
//   reg_write_out to 0. Without the macro, addresses wrap modulo 2**ADDR_W.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           kill the current op and any load in progress
//   valid_in        EX/MEM holds a real instruction
//   pc_in           instruction PC
//   alu_res         ALU result; low ADDR_W bits are the word address
//   wr_data         store data
//   mem_write       store
//   mem_read        load
//   reg_write_in    WB register write enable
//   wb_reg_in       WB destination register
//   stall           combinational; upstream holds its inputs while high
//   valid_out       MEM/WB holds a real instruction
//   pc_out          registered PC
//   alu_out         registered ALU result
//   read_data_out   registered load data
//   wb_reg_out      registered destination register
//   reg_write_out   registered write enable
//   mem_read_out    registered WB mux select
//   mem_err         registered address-range error (macro only)
// ---------------------------------------------------------------------------
module mem_stage_pipe #(
    parameter int DATA_W   = 32,
    parameter int PC_W     = 13,
    parameter int REG_W    = 3,
    parameter int ADDR_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [PC_W-1:0]   pc_in,
    input  logic [DATA_W-1:0] alu_res,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              mem_write,
    input  logic              mem_read,
    input  logic              reg_write_in,
    input  logic [REG_W-1:0]  wb_reg_in,
    output logic              stall,
    output logic              valid_out,
    output logic [PC_W-1:0]   pc_out,
    output logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] read_data_out,
    output logic [REG_W-1:0]  wb_reg_out,
    output logic              reg_write_out,
    output logic              mem_read_out
`ifdef MEM_STAGE_PIPE_ERR_EN
    ,
    output logic              mem_err
`endif
);

    localparam int         DEPTH = 2 ** ADDR_W;
    localparam logic [4:0] LAT5  = 5'(READ_LAT);

    typedef enum logic {
        IDLE,
        LOAD_WAIT
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [3:0]        cnt;
    state_t            state;
    logic              act;
    logic              is_load;
    logic              lat_pending;
    logic              addr_err;
    logic              do_store;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] read_word;

    assign act     = valid_in & ~flush;
    assign is_load = mem_read & ~mem_write;
    assign addr    = alu_res[ADDR_W-1:0];
    assign state   = (cnt == 4'd0) ? IDLE : LOAD_WAIT;

    // A multi-cycle load always spends its first cycle stalled. After
    // that, it keeps stalling until READ_LAT-1 wait cycles are counted.
    // The comparison is done in 5 bits so that cnt+1 cannot overflow.
    assign lat_pending = (state == IDLE) ? (READ_LAT > 1)
                                         : ((5'(cnt) + 5'd1) < LAT5);

    assign stall = act & is_load & lat_pending;

`ifdef MEM_STAGE_PIPE_ERR_EN
    assign addr_err = act & (mem_read | mem_write)
                    & (alu_res[DATA_W-1:ADDR_W] != '0);

    // The error flag holds while a load waits and is rewritten only on the
    // edge that completes an instruction.
    always_ff @(posedge clk) begin
        if (rst || !act) begin
            mem_err <= 1'b0;
        end else if (!stall) begin
            mem_err <= addr_err;
        end
    end
`else
    assign addr_err = 1'b0;
`endif

    assign read_word = mem[addr];

    // Flush arrives through act, and an out-of-range store is dropped.
    assign do_store = act & mem_write & ~stall & ~addr_err & ~rst;

    // The memory has no reset, so it can map onto a RAM.
    always_ff @(posedge clk) begin
        if (do_store) begin
            mem[addr] <= wr_data;
        end
    end

    // Load counter and MEM/WB register.
    // Priority order: reset, then flush/bubble, then stall hold, then the
    // completing edge. A flush or bubble clears only the control bits, so
    // the data fields keep their last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= 4'd0;
            valid_out     <= 1'b0;
            pc_out        <= '0;
            alu_out       <= '0;
            read_data_out <= '0;
            wb_reg_out    <= '0;
            reg_write_out <= 1'b0;
            mem_read_out  <= 1'b0;
        end else if (!act) begin
            cnt           <= 4'd0;
            valid_out     <= 1'b0;
            reg_write_out <= 1'b0;
            mem_read_out  <= 1'b0;
        end else if (stall) begin
            cnt <= cnt + 4'd1;
        end else begin
            cnt           <= 4'd0;
            valid_out     <= 1'b1;
            pc_out        <= pc_in;
            alu_out       <= alu_res;
            wb_reg_out    <= wb_reg_in;
            reg_write_out <= reg_write_in & ~addr_err;
            mem_read_out  <= mem_read;
            read_data_out <= (is_load && !addr_err) ? read_word : '0;
        end
    end

endmodule

// File: tb/tb_mem_stage_pipe.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_pipe
//
// Three copies of the MEM stage share one set of input signals. They differ
// only in READ_LAT:
//   u1: READ_LAT = 1
//   u3: READ_LAT = 3
//   u4: READ_LAT = 4
// Inputs change 1 ns after a rising edge. Registered outputs are checked
// at that same point, and stall is checked 1 ns later.
// ---------------------------------------------------------------------------
module tb_mem_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        valid_in;
    logic [12:0] pc_in;
    logic [31:0] alu_res;
    logic [31:0] wr_data;
    logic        mem_write;
    logic        mem_read;
    logic        reg_write_in;
    logic [2:0]  wb_reg_in;

    logic        stall_1, valid_1, rw_1, mr_1;
    logic [12:0] pc_1;
    logic [31:0] alu_1, rd_1;
    logic [2:0]  wb_1;

    logic        stall_3, valid_3, rw_3, mr_3;
    logic [12:0] pc_3;
    logic [31:0] alu_3, rd_3;
    logic [2:0]  wb_3;

    logic        stall_4, valid_4, rw_4, mr_4;
    logic [12:0] pc_4;
    logic [31:0] alu_4, rd_4;
    logic [2:0]  wb_4;

`ifdef MEM_STAGE_PIPE_ERR_EN
    logic        err_1, err_3, err_4;
    localparam logic [31:0] WRAP_EXP = 32'hDEADBEEF;
`else
    localparam logic [31:0] WRAP_EXP = 32'h000000A5;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_stage_pipe #(.READ_LAT(1)) u1 (
        .clk(clk), .rst(rst), .flush(flush), .valid_in(valid_in),
        .pc_in(pc_in), .alu_res(alu_res), .wr_data(wr_data),
        .mem_write(mem_write), .mem_read(mem_read),
        .reg_write_in(reg_write_in), .wb_reg_in(wb_reg_in),
        .stall(stall_1), .valid_out(valid_1), .pc_out(pc_1),
        .alu_out(alu_1), .read_data_out(rd_1), .wb_reg_out(wb_1),
        .reg_write_out(rw_1), .mem_read_out(mr_1)
`ifdef MEM_STAGE_PIPE_ERR_EN
        , .mem_err(err_1)
`endif
    );

    mem_stage_pipe #(.READ_LAT(3)) u3 (
        .clk(clk), .rst(rst), .flush(flush), .valid_in(valid_in),
        .pc_in(pc_in), .alu_res(alu_res), .wr_data(wr_data),
        .mem_write(mem_write), .mem_read(mem_read),
        .reg_write_in(reg_write_in), .wb_reg_in(wb_reg_in),
        .stall(stall_3), .valid_out(valid_3), .pc_out(pc_3),
        .alu_out(alu_3), .read_data_out(rd_3), .wb_reg_out(wb_3),
        .reg_write_out(rw_3), .mem_read_out(mr_3)
`ifdef MEM_STAGE_PIPE_ERR_EN
        , .mem_err(err_3)
`endif
    );

    mem_stage_pipe #(.READ_LAT(4)) u4 (
        .clk(clk), .rst(rst), .flush(flush), .valid_in(valid_in),
        .pc_in(pc_in), .alu_res(alu_res), .wr_data(wr_data),
        .mem_write(mem_write), .mem_read(mem_read),
        .reg_write_in(reg_write_in), .wb_reg_in(wb_reg_in),
        .stall(stall_4), .valid_out(valid_4), .pc_out(pc_4),
        .alu_out(alu_4), .read_data_out(rd_4), .wb_reg_out(wb_4),
        .reg_write_out(rw_4), .mem_read_out(mr_4)
`ifdef MEM_STAGE_PIPE_ERR_EN
        , .mem_err(err_4)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic v, input logic f,
                                  input logic [12:0] pc,
                                  input logic [31:0] alu,
                                  input logic [31:0] wd, input logic mw,
                                  input logic mr, input logic rw,
                                  input logic [2:0] wb);
        valid_in     = v;
        flush        = f;
        pc_in        = pc;
        alu_res      = alu;
        wr_data      = wd;
        mem_write    = mw;
        mem_read     = mr;
        reg_write_in = rw;
        wb_reg_in    = wb;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset
        rst = 1'b1;
        apply_stimulus(0, 0, 13'h0, 32'h0, 32'h0, 0, 0, 0, 3'd0);
        repeat (2) tick();
        check_output("rst_valid1", 32'(valid_1), 32'd0);
        check_output("rst_rd1", rd_1, 32'd0);
        check_output("rst_pc3", 32'(pc_3), 32'd0);
        check_output("rst_mr3", 32'(mr_3), 32'd0);
        check_output("rst_alu4", alu_4, 32'd0);
        check_output("rst_stall3", 32'(stall_3), 32'd0);
        rst = 1'b0;

        // Store 0xDEADBEEF at word 5
        apply_stimulus(1, 0, 13'h010, 32'd5, 32'hDEADBEEF, 1, 0, 0, 3'd0);
        #1 check_output("st_stall3", 32'(stall_3), 32'd0);
        tick();
        check_output("st_valid1", 32'(valid_1), 32'd1);
        check_output("st_rd1", rd_1, 32'd0);
        check_output("st_pc1", 32'(pc_1), 32'h010);
        check_output("st_mr1", 32'(mr_1), 32'd0);

        // Load from word 5: one cycle on u1, three cycles on u3
        apply_stimulus(1, 0, 13'h014, 32'd5, 32'h0, 0, 1, 1, 3'd3);
        #1 check_output("ld_stall1", 32'(stall_1), 32'd0);
        check_output("ld_stall3_c1", 32'(stall_3), 32'd1);
        tick();
        check_output("ld_rd1", rd_1, 32'hDEADBEEF);
        check_output("ld_valid1", 32'(valid_1), 32'd1);
        check_output("ld_mr1", 32'(mr_1), 32'd1);
        check_output("ld_wb1", 32'(wb_1), 32'd3);
        check_output("ld_hold_pc3", 32'(pc_3), 32'h010);
        check_output("ld_stall3_c2", 32'(stall_3), 32'd1);
        check_output("ld_stall1_c2", 32'(stall_1), 32'd0);
        tick();
        check_output("ld_stall3_c3", 32'(stall_3), 32'd0);
        check_output("ld_hold_rd3", rd_3, 32'd0);
        tick();
        check_output("ld_rd3", rd_3, 32'hDEADBEEF);
        check_output("ld_pc3", 32'(pc_3), 32'h014);
        check_output("ld_mr3", 32'(mr_3), 32'd1);
        check_output("ld_rw3", 32'(rw_3), 32'd1);
        check_output("ld_valid3", 32'(valid_3), 32'd1);

        // Bubble: control bits clear, data fields hold
        apply_stimulus(0, 0, 13'h0, 32'h0, 32'h0, 0, 0, 0, 3'd0);
        tick();
        check_output("bub_valid3", 32'(valid_3), 32'd0);
        check_output("bub_rw3", 32'(rw_3), 32'd0);
        check_output("bub_mr3", 32'(mr_3), 32'd0);
        check_output("bub_pc3", 32'(pc_3), 32'h014);
        check_output("bub_rd3", rd_3, 32'hDEADBEEF);

        // Flush on the 2nd cycle of a u3 load, then a full reload
        apply_stimulus(1, 0, 13'h018, 32'd5, 32'h0, 0, 1, 1, 3'd4);
        #1 check_output("fl_stall3_c1", 32'(stall_3), 32'd1);
        tick();
        flush = 1'b1;
        #1 check_output("fl_stall3_c2", 32'(stall_3), 32'd0);
        tick();
        check_output("fl_valid3", 32'(valid_3), 32'd0);
        check_output("fl_rw3", 32'(rw_3), 32'd0);
        check_output("fl_rd3", rd_3, 32'hDEADBEEF);
        check_output("fl_valid1", 32'(valid_1), 32'd0);
        apply_stimulus(1, 0, 13'h01C, 32'd5, 32'h0, 0, 1, 1, 3'd4);
        #1 check_output("rl_stall3_c1", 32'(stall_3), 32'd1);
        tick();
        check_output("rl_stall3_c2", 32'(stall_3), 32'd1);
        tick();
        check_output("rl_stall3_c3", 32'(stall_3), 32'd0);
        check_output("rl_hold_valid3", 32'(valid_3), 32'd0);
        tick();
        check_output("rl_valid3", 32'(valid_3), 32'd1);
        check_output("rl_rd3", rd_3, 32'hDEADBEEF);
        check_output("rl_pc3", 32'(pc_3), 32'h01C);

        // A flushed store must not overwrite word 7
        apply_stimulus(1, 0, 13'h020, 32'd7, 32'h00001111, 1, 0, 0, 3'd0);
        tick();
        check_output("st7_pc1", 32'(pc_1), 32'h020);
        apply_stimulus(1, 1, 13'h024, 32'd7, 32'h00001234, 1, 0, 0, 3'd0);
        tick();
        check_output("fst_valid1", 32'(valid_1), 32'd0);
        check_output("fst_pc1", 32'(pc_1), 32'h020);
        apply_stimulus(1, 0, 13'h028, 32'd7, 32'h0, 0, 1, 1, 3'd5);
        tick();
        check_output("fst_rd1", rd_1, 32'h00001111);
        repeat (2) tick();
        check_output("fst_rd3", rd_3, 32'h00001111);
        check_output("fst_wb3", 32'(wb_3), 32'd5);

        // Upper address bits: a store to 0x105 either wraps onto word 5
        // or is rejected as out of range, depending on the build
        apply_stimulus(1, 0, 13'h030, 32'h105, 32'h000000A5, 1, 0, 1, 3'd6);
        tick();
        check_output("wr_alu1", alu_1, 32'h105);
`ifdef MEM_STAGE_PIPE_ERR_EN
        check_output("wr_rw1", 32'(rw_1), 32'd0);
        check_output("wr_err1", 32'(err_1), 32'd1);
`else
        check_output("wr_rw1", 32'(rw_1), 32'd1);
`endif
        apply_stimulus(1, 0, 13'h034, 32'd5, 32'h0, 0, 1, 1, 3'd6);
        tick();
        check_output("wr_rd1", rd_1, WRAP_EXP);
`ifdef MEM_STAGE_PIPE_ERR_EN
        check_output("wr_err1_clr", 32'(err_1), 32'd0);
`endif
        repeat (2) tick();
        check_output("wr_rd3", rd_3, WRAP_EXP);

        // Reset during LOAD_WAIT on u4, then a plain ALU op
        apply_stimulus(0, 0, 13'h0, 32'h0, 32'h0, 0, 0, 0, 3'd0);
        tick();
        apply_stimulus(1, 0, 13'h040, 32'd5, 32'h0, 0, 1, 1, 3'd1);
        #1 check_output("rw_stall4_c1", 32'(stall_4), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        apply_stimulus(1, 0, 13'h044, 32'h77, 32'h0, 0, 0, 1, 3'd2);
        #1 check_output("rw_stall4", 32'(stall_4), 32'd0);
        check_output("rw_pc4", 32'(pc_4), 32'd0);
        check_output("rw_rd4", rd_4, 32'd0);
        check_output("rw_alu4", alu_4, 32'd0);
        check_output("rw_wb4", 32'(wb_4), 32'd0);
        tick();
        check_output("alu_valid4", 32'(valid_4), 32'd1);
        check_output("alu_alu4", alu_4, 32'h77);
        check_output("alu_rd4", rd_4, 32'd0);
        check_output("alu_pc4", 32'(pc_4), 32'h044);
        check_output("alu_rw4", 32'(rw_4), 32'd1);
        check_output("alu_mr4", 32'(mr_4), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
